// File: rtl/key_scan_wb.sv
// rtl/key_scan_wb.sv - Wishbone 2x4 key matrix scanner with per-key debounce and edge interrupt
module key_scan_wb #(
  parameter int         PRESCALE  = 256,
  parameter logic [7:0] DIV_RESET = 8'd15,
  parameter logic [3:0] DEB_RESET = 4'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] wb_a,
  input  logic [7:0] wb_din,
  output logic [7:0] wb_dout,
  input  logic       wb_cyc,
  input  logic       wb_stb,
  input  logic       wb_we,
  output logic       wb_ack,
  output logic       wb_stall,
  input  logic [3:0] key_in,
  output logic [1:0] key_out,
  output logic [7:0] key,
  output logic       irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic {COL0, COL1} scan_state_t;

  scan_state_t state, state_next;

  logic [3:0]      sync_a, sync_b;
  logic [PW-1:0]   pre_cnt;
  logic [7:0]      div_cnt;
  logic            pre_tick, scan_tick;
  logic [7:0]      scan_div;
  logic [3:0]      deb_len;
  logic [7:0]      key_edge;
  logic [7:0]      irq_en;
  logic [7:0][3:0] cnt, cnt_next;
  logic [7:0]      key_next, edge_set;
  logic            col_sel;
  logic            req, wr, wr_div;
  logic [7:0]      edge_clr, rdata;

  assign wb_stall = 1'b0;
  assign irq      = |(key_edge & irq_en);

  assign req      = wb_cyc & wb_stb & ~wb_ack;
  assign wr       = req & wb_we;
  assign wr_div   = wr && (wb_a == 4'h2);
  assign edge_clr = (wr && (wb_a == 4'h1)) ? wb_din : 8'h00;

  // Rows float high when idle, so the synchronizer starts out "no key"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 4'hF;
      sync_b <= 4'hF;
    end else begin
      sync_a <= key_in;
      sync_b <= sync_a;
    end
  end

  assign pre_tick  = (pre_cnt == PRE_LAST);
  assign scan_tick = pre_tick && (div_cnt == scan_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      div_cnt <= 8'h00;
    end else if (wr_div) begin
      pre_cnt <= '0;
      div_cnt <= 8'h00;
    end else if (pre_tick) begin
      pre_cnt <= '0;
      div_cnt <= (div_cnt == scan_div) ? 8'h00 : div_cnt + 8'h01;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COL0;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    key_out    = 2'b10;
    col_sel    = 1'b0;
    case (state)
      COL0: begin
        key_out = 2'b10;
        if (scan_tick) state_next = COL1;
      end
      COL1: begin
        key_out = 2'b01;
        col_sel = 1'b1;
        if (scan_tick) state_next = COL0;
      end
      default: state_next = COL0;
    endcase
  end

  // The driven column is sampled at the end of its tick period, then released
  logic [7:0] samp8;
  logic [7:0] col_hit;
  logic [4:0] cnt_sum;

  assign samp8   = {~sync_b, ~sync_b};
  assign col_hit = scan_tick ? (col_sel ? 8'hF0 : 8'h0F) : 8'h00;

  always_comb begin
    key_next = key;
    cnt_next = cnt;
    edge_set = 8'h00;
    cnt_sum  = 5'd0;
    for (int i = 0; i < 8; i++) begin
      cnt_sum = {1'b0, cnt[i]} + 5'd1;
      if (col_hit[i]) begin
        if (samp8[i] == key[i]) begin
          cnt_next[i] = 4'd0;
        end else if ((deb_len == 4'd0) || (cnt_sum >= {1'b0, deb_len})) begin
          key_next[i] = samp8[i];
          cnt_next[i] = 4'd0;
          edge_set[i] = samp8[i];
        end else begin
          cnt_next[i] = (cnt[i] == 4'hF) ? 4'hF : cnt_sum[3:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key      <= 8'h00;
      cnt      <= '0;
      key_edge <= 8'h00;
    end else begin
      key      <= key_next;
      cnt      <= cnt_next;
      key_edge <= (key_edge & ~edge_clr) | edge_set;
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (wb_a)
      4'h0:    rdata = key;
      4'h1:    rdata = key_edge;
      4'h2:    rdata = scan_div;
      4'h3:    rdata = {4'h0, deb_len};
      4'h4:    rdata = irq_en;
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack   <= 1'b0;
      wb_dout  <= 8'h00;
      scan_div <= DIV_RESET;
      deb_len  <= DEB_RESET;
      irq_en   <= 8'h00;
    end else begin
      wb_ack <= req;
      if (req && !wb_we) wb_dout <= rdata;
      if (wr) begin
        case (wb_a)
          4'h2:    scan_div <= wb_din;
          4'h3:    deb_len  <= wb_din[3:0];
          4'h4:    irq_en   <= wb_din;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_scan_wb.sv
// tb/tb_key_scan_wb.sv - directed bench for key_scan_wb with a cycle-level reference model
module tb_key_scan_wb;
  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] wb_a = 4'h0;
  logic [7:0] wb_din = 8'h00;
  logic [7:0] wb_dout;
  logic       wb_cyc = 1'b0;
  logic       wb_stb = 1'b0;
  logic       wb_we = 1'b0;
  logic       wb_ack;
  logic       wb_stall;
  logic [3:0] key_in;
  logic [1:0] key_out;
  logic [7:0] key;
  logic       irq;

  logic [7:0] pressed = 8'h00;
  logic       started = 1'b0;
  int n_pass = 0;
  int n_total = 0;

  key_scan_wb #(.PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst(rst), .wb_a(wb_a), .wb_din(wb_din), .wb_dout(wb_dout),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack),
    .wb_stall(wb_stall), .key_in(key_in), .key_out(key_out), .key(key), .irq(irq)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    key_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (pressed[r] && key_out == 2'b10) key_in[r] = 1'b0;
      if (pressed[4 + r] && key_out == 2'b01) key_in[r] = 1'b0;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: edge counter modulo the tick period, key_in delay line, per-key counts
  logic [7:0] m_key, m_edge, m_div, m_irqen, m_dout, setv, clrv;
  logic [3:0] m_deb, h1, h2, samp;
  logic       m_col, m_ack, req, tick;
  int         m_n, idx;
  int         m_cnt [8];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_key = 0; m_edge = 0; m_div = 8'h0F; m_deb = 4'h4; m_irqen = 0; m_dout = 0;
      m_col = 0; m_ack = 0; m_n = 0; h1 = 4'hF; h2 = 4'hF;
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    end else begin
      samp = ~h2; h2 = h1; h1 = key_in;
      req = wb_cyc && wb_stb && !m_ack;
      if (req && !wb_we) begin
        case (wb_a)
          4'h0: m_dout = m_key;
          4'h1: m_dout = m_edge;
          4'h2: m_dout = m_div;
          4'h3: m_dout = {4'h0, m_deb};
          4'h4: m_dout = m_irqen;
          default: m_dout = 8'h00;
        endcase
      end
      tick = ((m_n + 1) % (PRESCALE * (int'(m_div) + 1))) == 0;
      m_n++;
      setv = 0;
      if (tick) begin
        for (int r = 0; r < 4; r++) begin
          idx = (m_col ? 4 : 0) + r;
          if (samp[r] == m_key[idx]) m_cnt[idx] = 0;
          else if (m_deb == 0 || m_cnt[idx] + 1 >= int'(m_deb)) begin
            m_key[idx] = samp[r];
            setv[idx] = samp[r];
            m_cnt[idx] = 0;
          end else m_cnt[idx] = (m_cnt[idx] >= 15) ? 15 : m_cnt[idx] + 1;
        end
        m_col = ~m_col;
      end
      clrv = 0;
      if (req && wb_we) begin
        case (wb_a)
          4'h1: clrv = wb_din;
          4'h2: begin m_div = wb_din; m_n = 0; end
          4'h3: m_deb = wb_din[3:0];
          4'h4: m_irqen = wb_din;
          default: ;
        endcase
      end
      m_edge = (m_edge & ~clrv) | setv;
      m_ack = req;
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      check("key_out", 8'(key_out), m_col ? 8'h01 : 8'h02);
      check("key", key, m_key);
      check("irq", 8'(irq), 8'(|(m_edge & m_irqen)));
      check("wb_ack", 8'(wb_ack), 8'(m_ack));
      check("wb_dout", wb_dout, m_dout);
      check("wb_stall", 8'(wb_stall), 8'h00);
    end
  end

  task automatic wb_write(input logic [3:0] a, input logic [7:0] d);
    wb_a = a; wb_din = d; wb_we = 1; wb_cyc = 1; wb_stb = 1;
    @(negedge clk);
    check("wr_ack", 8'(wb_ack), 8'h01);
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    @(negedge clk);
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [7:0] d);
    wb_a = a; wb_we = 0; wb_cyc = 1; wb_stb = 1;
    @(negedge clk);
    check("rd_ack", 8'(wb_ack), 8'h01);
    d = wb_dout;
    wb_cyc = 0; wb_stb = 0;
    @(negedge clk);
  endtask

  // Returns at the negedge following the scan edge that moves key_out from `from` to `to`
  task automatic wait_col(input logic [1:0] from, input logic [1:0] to);
    logic [1:0] prev;
    logic seen;
    prev = key_out; seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (prev == from && key_out == to) seen = 1;
      prev = key_out;
    end
    if (!seen) check("col_wait_timeout", 8'h00, 8'h01);
  endtask

  initial begin
    logic [7:0] d;
    int c;
    logic done;
    repeat (3) @(negedge clk);
    rst = 0;
    started = 1;
    check("rst_key", key, 8'h00);
    check("rst_key_out", 8'(key_out), 8'h02);
    check("rst_irq", 8'(irq), 8'h00);
    check("rst_ack", 8'(wb_ack), 8'h00);
    check("rst_dout", wb_dout, 8'h00);
    wb_read(4'h2, d); check("rst_scan_div", d, 8'h0F);
    wb_read(4'h3, d); check("rst_debounce", d, 8'h04);
    wb_read(4'h1, d); check("rst_key_edge", d, 8'h00);

    wb_write(4'h2, 8'h01);
    for (int k = 0; k < 2; k++) begin
      wait_col(2'b10, 2'b01);
      c = 0; done = 0;
      for (int j = 0; j < 40 && !done; j++) begin
        @(negedge clk); c++;
        if (key_out != 2'b01) done = 1;
      end
      check("col_period", 8'(c), 8'd8);
    end

    pressed = 8'h10;
    repeat (100) @(negedge clk);
    check("press_key4", key, 8'h10);
    wb_read(4'h1, d); check("press_edge4", d, 8'h10);
    pressed = 8'h00;
    repeat (100) @(negedge clk);
    check("release_key4", key, 8'h00);

    for (int k = 0; k < 8; k++) begin
      wait_col(2'b10, 2'b01);
      pressed[0] = ~pressed[0];
    end
    check("bounce_stays_0", 8'(key[0]), 8'h00);
    pressed[0] = 0;
    repeat (2) wait_col(2'b10, 2'b01);
    pressed[0] = 1;
    repeat (3) wait_col(2'b10, 2'b01);
    check("deb_3rd_sample", 8'(key[0]), 8'h00);
    wait_col(2'b10, 2'b01);
    check("deb_4th_sample", 8'(key[0]), 8'h01);

    wb_write(4'h3, 8'h00);
    wait_col(2'b10, 2'b01);
    pressed[1] = 1;
    wait_col(2'b10, 2'b01);
    check("deb0_1st_sample", key, 8'h03);

    wb_write(4'h4, 8'h10);
    wb_write(4'h1, 8'hFF);
    check("irq_cleared", 8'(irq), 8'h00);
    pressed[4] = 1;
    repeat (2) wait_col(2'b01, 2'b10);
    check("irq_on_press", 8'(irq), 8'h01);
    wb_write(4'h1, 8'h10);
    check("irq_after_w1c", 8'(irq), 8'h00);
    pressed[4] = 0;
    repeat (2) wait_col(2'b01, 2'b10);
    check("key4_released", key, 8'h03);

    wait_col(2'b10, 2'b01);
    pressed[4] = 1;
    repeat (7) @(negedge clk);
    wb_write(4'h1, 8'h10);
    wb_read(4'h1, d); check("set_beats_clear", d, 8'h10);
    check("irq_set_wins", 8'(irq), 8'h01);

    wb_a = 4'h0; wb_we = 0; wb_cyc = 1; wb_stb = 1;
    check("b2b_ack0", 8'(wb_ack), 8'h00);
    @(negedge clk); check("b2b_ack1", 8'(wb_ack), 8'h01);
    @(negedge clk); check("b2b_ack2", 8'(wb_ack), 8'h00);
    @(negedge clk); check("b2b_ack3", 8'(wb_ack), 8'h01);
    wb_cyc = 0; wb_stb = 0;
    @(negedge clk);
    wb_read(4'h7, d); check("unmapped_read", d, 8'h00);
    wb_write(4'h3, 8'hFF);
    wb_read(4'h3, d); check("debounce_4bit", d, 8'h0F);

    wb_write(4'h3, 8'h02);
    wb_write(4'h4, 8'hFF);
    pressed = 8'h22;
    done = 0;
    for (int j = 0; j < 400 && !done; j++) begin
      @(negedge clk);
      if (key == 8'h22) done = 1;
    end
    check("key_22", key, 8'h22);
    wait_col(2'b10, 2'b01);
    pressed[1] = 0;
    wait_col(2'b10, 2'b01);
    wb_read(4'h0, d); check("pre_rst_read", d, 8'h22);
    check("pre_rst_irq", 8'(irq), 8'h01);
    #2 rst = 1;
    #1;
    check("async_rst_key", key, 8'h00);
    check("async_rst_key_out", 8'(key_out), 8'h02);
    check("async_rst_irq", 8'(irq), 8'h00);
    check("async_rst_ack", 8'(wb_ack), 8'h00);
    check("async_rst_dout", wb_dout, 8'h00);
    repeat (2) @(negedge clk);
    rst = 0;
    wb_read(4'h2, d); check("post_rst_scan_div", d, 8'h0F);
    wb_read(4'h4, d); check("post_rst_irq_en", d, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_scan_wb.md
Name: key_scan_wb

Overview:
- Wishbone slave peripheral that scans the 2x4 handheld keyboard matrix (KEY_OUT columns, KEY_IN rows) and debounces each key.
- Presents the 8-bit pressed-key vector to the VerilogBoy core's key input.
- Exposes state, press-edge, scan timing and interrupt registers in the 3F00-3FFF peripheral window.
- Responds to the memory controller's Wishbone initiator, alongside the DSI controller.

Parameters:
- PRESCALE, 256, core clocks per scan-divider tick.
- DIV_RESET, 8'd15, reset value of SCAN_DIV register.
- DEB_RESET, 4'd4, reset value of DEBOUNCE register.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous reset, active-high.
- wb_a  input  4  register address.
- wb_din  input  8  write data, master to slave.
- wb_dout  output  8  read data, slave to master.
- wb_cyc  input  1  Wishbone cycle.
- wb_stb  input  1  Wishbone strobe.
- wb_we  input  1  write enable.
- wb_ack  output  1  acknowledge.
- wb_stall  output  1  stall, tied 0.
- key_in  input  4  matrix rows, active-low, asynchronous; pulled up externally.
- key_out  output  2  column drive, active-low, one-hot-low.
- key  output  8  debounced key state, 1 = pressed; bit = col*4 + row.
- irq  output  1  level interrupt, equals |(KEY_EDGE & IRQ_EN).

Behaviour:
- Reset (async, all state):
  - key_out = 2'b10 (column 0 driven); key = 0; wb_ack = 0; wb_dout = 0; irq = 0.
  - SCAN_DIV = DIV_RESET; DEBOUNCE = DEB_RESET; KEY_EDGE = 0; IRQ_EN = 0.
  - All debounce counters = 0; scan FSM in COL0.
- key_in passes through a 2-FF synchronizer before any use.
- Tick generator:
  - Prescaler counts 0..PRESCALE-1, then pulses pre_tick.
  - Divider counts pre_ticks 0..SCAN_DIV, then pulses scan_tick.
  - Resulting scan_tick period = PRESCALE*(SCAN_DIV+1) clocks.
  - A write to SCAN_DIV restarts both counters at 0.
- Scan FSM states COL0, COL1; transitions only on scan_tick. Column settles for a full tick period before sampling.
  - COL0: key_out = 2'b10. On scan_tick, sample ~sync_in into raw[3:0], then go to COL1.
  - COL1: key_out = 2'b01. On scan_tick, sample ~sync_in into raw[7:4], then go to COL0.
- Debounce, per key i, evaluated on the same scan_tick that samples key i (4-bit counter cnt[i]):
  - raw[i] == key[i]: cnt[i] <= 0.
  - Otherwise cnt[i] <= cnt[i] + 1.
  - When cnt[i] + 1 >= DEBOUNCE, or DEBOUNCE == 0: key[i] <= raw[i], cnt[i] <= 0.
  - Counter saturates at 15, never wraps.
  - A 0->1 transition of key[i] sets KEY_EDGE[i].
- Registers (wb_a):
  - 0x0 KEY_STATE, RO = key.
  - 0x1 KEY_EDGE, R/W1C.
  - 0x2 SCAN_DIV, RW 8b.
  - 0x3 DEBOUNCE, RW, low 4 bits; upper bits read 0.
  - 0x4 IRQ_EN, RW 8b.
  - 0x5-0xF read 0; writes ignored.
- Wishbone:
  - Request = wb_cyc & wb_stb & ~wb_ack.
  - wb_ack asserts exactly one clock after the request and lasts one cycle, giving one access per two clocks under continuous strobe.
  - wb_dout is registered in the same edge as wb_ack and holds until the next read.
  - Writes take effect on the acking edge.
  - wb_cyc dropping mid-cycle: ack still issues next clock; master ignores it.
  - wb_stall = 0 always.
- Simultaneous events:
  - A KEY_EDGE set and a W1C clear of the same bit in one clock: set wins.
  - Other bits clear normally.
- irq updates combinationally from registered KEY_EDGE and IRQ_EN, so it follows the register state without added latency.

Test Plan:
- Reset -> key=00, key_out=2'b10, KEY_EDGE=00, SCAN_DIV reads 0F, DEBOUNCE reads 04, irq=0, wb_ack=0.
- PRESCALE=4, SCAN_DIV=1 -> key_out toggles every 8 clocks. Hold key_in=4'b1110 while COL1 is driven, for >=4 COL1 samples -> key=8'h10 and KEY_EDGE=8'h10.
- Bouncing row (toggle every scan) with DEBOUNCE=4 -> key stays 00. Stable for 4 samples -> key bit sets on the 4th sample. DEBOUNCE=0 -> updates on the 1st sample.
- IRQ_EN=8'h10; press key 4 -> irq=1. Write 8'h10 to 0x1 -> irq=0 the clock after ack. Clear issued on the same edge as a new set -> bit stays 1.
- Back-to-back reads with cyc/stb held high -> ack pattern 0,1,0,1. Read of 0x7 -> 00. Write 0xFF to 0x3 -> reads 0F.
- Assert rst mid-scan with key=8'h22 and cnt nonzero -> all outputs return to reset values immediately, without waiting for a clock.
